// File: rtl/btc_pkg.sv
// Shared definitions for the nonce result buffer: register map, CTRL bits, ID word
// and the STATUS word layout.
package btc_pkg;

    typedef enum logic [1:0] {
        RegStatus = 2'd0,
        RegData   = 2'd1,
        RegCtrl   = 2'd2,
        RegId     = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_CLR_OVF = 2;

    localparam logic [31:0] ID_VALUE = 32'h4E4F4E43;

    localparam int unsigned OVF_CNT_W = 8;

    localparam int unsigned STAT_EMPTY       = 8;
    localparam int unsigned STAT_FULL        = 9;
    localparam int unsigned STAT_OVF         = 10;
    localparam int unsigned STAT_OVF_CNT_LSB = 16;

    // Count is zero-extended into the low byte; the FIFO never exceeds 128 entries.
    function automatic logic [31:0] pack_status(input logic [7:0]           count,
                                                input logic                 empty,
                                                input logic                 full,
                                                input logic                 ovf,
                                                input logic [OVF_CNT_W-1:0] ovf_cnt);
        logic [31:0] word;
        word                                              = '0;
        word[7:0]                                         = count;
        word[STAT_EMPTY]                                  = empty;
        word[STAT_FULL]                                   = full;
        word[STAT_OVF]                                    = ovf;
        word[STAT_OVF_CNT_LSB +: OVF_CNT_W]               = ovf_cnt;
        return word;
    endfunction

endpackage

// File: rtl/btc_sync_fifo.sv
// Flop-based synchronous FIFO with zero read latency (dout shows the head entry).
// Flush overrides push and pop; a push into a full FIFO is accepted only alongside a pop.
module btc_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop & ~empty & ~flush;
        do_push = push & ~flush & (~full | do_pop);
    end

    // Pointers are exactly AW bits, so increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/btc_nonce_fifo.sv
// Golden-nonce result buffer: captures nonces from the hash core into a FIFO and exposes
// it, plus overflow tracking and an interrupt enable, through a Wishbone register window.
module btc_nonce_fifo
    import btc_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          found_valid,
    input  logic [DW-1:0] found_nonce,
    input  logic          wb_cycle,
    input  logic          wb_strobe,
    input  logic          wb_we,
    input  logic [3:0]    wb_addr,
    input  logic [31:0]   wb_wdata,
    output logic [31:0]   wb_rdata,
    output logic          wb_ack,
    output logic          irq
);

    logic                 req;
    reg_sel_e             sel;
    logic [31:0]          read_word;

    logic                 ack_q;
    logic [31:0]          rdata_q;
    logic                 pop_pend_q;
    logic                 ctrl_wr_q;
    logic [2:0]           ctrl_wdata_q;

    logic                 irq_en_q;
    logic                 ovf_q;
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    logic                 flush;
    logic                 clr_ovf;
    logic                 drop;

    logic [DW-1:0]        fifo_dout;
    logic [AW:0]          fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    btc_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (found_valid),
        .din   (found_nonce),
        .pop   (pop_pend_q),
        .flush (flush),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req = wb_cycle & wb_strobe & ~ack_q;
    assign sel = reg_sel_e'(wb_addr[3:2]);

    // Side effects are latched at the request edge and applied during the ack cycle.
    assign flush   = ctrl_wr_q & ctrl_wdata_q[CTRL_FLUSH];
    assign clr_ovf = ctrl_wr_q & ctrl_wdata_q[CTRL_CLR_OVF];
    assign drop    = found_valid & ~flush & fifo_full & ~pop_pend_q;

    always_comb begin
        read_word = '0;
        unique case (sel)
            RegStatus: read_word = pack_status(8'(fifo_count), fifo_empty, fifo_full,
                                               ovf_q, ovf_cnt_q);
            RegData:   read_word = fifo_empty ? 32'h0 : 32'(fifo_dout);
            RegCtrl:   read_word[CTRL_IRQ_EN] = irq_en_q;
            RegId:     read_word = ID_VALUE;
            default:   read_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            pop_pend_q   <= 1'b0;
            ctrl_wr_q    <= 1'b0;
            ctrl_wdata_q <= '0;
        end else begin
            ack_q        <= req;
            rdata_q      <= (req & ~wb_we) ? read_word : 32'h0;
            pop_pend_q   <= req & ~wb_we & (sel == RegData) & ~fifo_empty;
            ctrl_wr_q    <= req & wb_we & (sel == RegCtrl);
            ctrl_wdata_q <= wb_wdata[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            if (ctrl_wr_q) begin
                irq_en_q <= ctrl_wdata_q[CTRL_IRQ_EN];
            end
            if (clr_ovf) begin
                ovf_q     <= 1'b0;
                ovf_cnt_q <= '0;
            end else if (drop) begin
                ovf_q <= 1'b1;
                if (ovf_cnt_q != '1) begin
                    ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
                end
            end
        end
    end

    assign wb_ack   = ack_q;
    assign wb_rdata = rdata_q;
    assign irq      = (fifo_count != '0) & irq_en_q;

endmodule

// File: tb/tb_btc_nonce_fifo.sv
// Scoreboard bench for btc_nonce_fifo: a queue models FIFO contents and overflow state,
// DATA reads are compared against popped expectations.
module tb_btc_nonce_fifo;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] ID    = 32'h4E4F4E43;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        found_valid;
    logic [31:0] found_nonce;
    logic        wb_cycle;
    logic        wb_strobe;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_ack;
    logic        irq;

    int          vectors     = 0;
    int          miscompares = 0;

    logic [31:0] model_q[$];
    bit          m_ovf     = 0;
    int          m_ovf_cnt = 0;

    always #5 clk = ~clk;

    btc_nonce_fifo #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .found_valid (found_valid),
        .found_nonce (found_nonce),
        .wb_cycle    (wb_cycle),
        .wb_strobe   (wb_strobe),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_wdata    (wb_wdata),
        .wb_rdata    (wb_rdata),
        .wb_ack      (wb_ack),
        .irq         (irq)
    );

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int          n;
        n = model_q.size();
        s = 32'(n);
        if (n == 0)     s = s | (32'd1 << 8);
        if (n == DEPTH) s = s | (32'd1 << 9);
        if (m_ovf)      s = s | (32'd1 << 10);
        s = s | (32'(m_ovf_cnt) << 16);
        return s;
    endfunction

    task automatic push_nonce(input logic [31:0] n);
        found_valid = 1'b1;
        found_nonce = n;
        if (model_q.size() < DEPTH) begin
            model_q.push_back(n);
        end else begin
            m_ovf = 1;
            if (m_ovf_cnt < 255) m_ovf_cnt++;
        end
        @(negedge clk);
        found_valid = 1'b0;
    endtask

    // Called and returns at a falling edge; optional push is driven during the ack cycle.
    task automatic wb_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                           input logic push_on_ack, input logic [31:0] nonce,
                           output logic [31:0] rdata);
        int n = 0;
        wb_cycle  = 1'b1;
        wb_strobe = 1'b1;
        wb_we     = we;
        wb_addr   = addr;
        wb_wdata  = wdata;
        @(negedge clk);
        while (!wb_ack && n < 4) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!wb_ack) begin
            $display("FAIL ack_timeout got=0 want=1 addr=%h", addr);
            miscompares++;
        end
        rdata     = wb_rdata;
        wb_cycle  = 1'b0;
        wb_strobe = 1'b0;
        wb_we     = 1'b0;
        if (push_on_ack) begin
            found_valid = 1'b1;
            found_nonce = nonce;
        end
        @(negedge clk);
        found_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0;
        found_valid = 0; found_nonce = 0;
        wb_cycle = 0; wb_strobe = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_nonce(32'h55);
        wb_cycle  = 1'b1;
        wb_strobe = 1'b1;
        wb_addr   = 4'h0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (wb_ack !== 1'b0) begin
            $display("FAIL reset_ack got=%b want=0", wb_ack); miscompares++;
        end
        vectors++;
        if (wb_rdata !== 32'h0) begin
            $display("FAIL reset_rdata got=%h want=0", wb_rdata); miscompares++;
        end
        vectors++;
        if (irq !== 1'b0) begin
            $display("FAIL reset_irq got=%b want=0", irq); miscompares++;
        end
        wb_cycle  = 1'b0;
        wb_strobe = 1'b0;
        model_q.delete();
        m_ovf = 0; m_ovf_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0000_0100) begin
            $display("FAIL reset_status got=%h want=%h", rd, 32'h0000_0100); miscompares++;
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] rd;
        logic [31:0] exp;
        push_nonce(32'h11);
        push_nonce(32'h22);
        push_nonce(32'h33);
        wb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h3) begin
            $display("FAIL status_count3 got=%h want=%h", rd, 32'h3); miscompares++;
        end
        for (int i = 0; i < 4; i++) begin
            exp = (model_q.size() != 0) ? model_q.pop_front() : 32'h0;
            wb_xfer(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, rd);
            vectors++;
            if (rd !== exp) begin
                $display("FAIL data_read%0d got=%h want=%h", i, rd, exp); miscompares++;
            end
        end
        wb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== exp_status()) begin
            $display("FAIL status_after_drain got=%h want=%h", rd, exp_status()); miscompares++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [31:0] exp;
        for (int i = 0; i < 10; i++) push_nonce(32'h1000 + 32'(i));
        wb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0002_0608) begin
            $display("FAIL ovf_status got=%h want=%h", rd, 32'h0002_0608); miscompares++;
        end
        for (int i = 0; i < 8; i++) begin
            exp = model_q.pop_front();
            wb_xfer(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, rd);
            vectors++;
            if (rd !== exp) begin
                $display("FAIL ovf_drain%0d got=%h want=%h", i, rd, exp); miscompares++;
            end
        end
        wb_xfer(1'b1, 4'h8, 32'h4, 1'b0, 32'h0, rd);
        m_ovf = 0; m_ovf_cnt = 0;
        wb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0000_0100) begin
            $display("FAIL ovf_clear got=%h want=%h", rd, 32'h0000_0100); miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) push_nonce(32'h2000 + 32'(i));
        exp = model_q.pop_front();
        model_q.push_back(32'hBEEF);
        wb_xfer(1'b0, 4'h4, 32'h0, 1'b1, 32'hBEEF, rd);
        vectors++;
        if (rd !== exp) begin
            $display("FAIL simul_pop got=%h want=%h", rd, exp); miscompares++;
        end
        wb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0000_0208) begin
            $display("FAIL simul_status got=%h want=%h", rd, 32'h0000_0208); miscompares++;
        end
        for (int i = 0; i < 8; i++) begin
            exp = model_q.pop_front();
            wb_xfer(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, rd);
            vectors++;
            if (rd !== exp) begin
                $display("FAIL simul_drain%0d got=%h want=%h", i, rd, exp); miscompares++;
            end
        end
        vectors++;
        if (rd !== 32'hBEEF) begin
            $display("FAIL simul_last got=%h want=%h", rd, 32'hBEEF); miscompares++;
        end
    endtask

    task automatic test_flush_vs_push();
        logic [31:0] rd;
        push_nonce(32'hA1);
        push_nonce(32'hA2);
        wb_xfer(1'b1, 4'h8, 32'h2, 1'b1, 32'hAB, rd);
        model_q.delete();
        wb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0000_0100) begin
            $display("FAIL flush_status got=%h want=%h", rd, 32'h0000_0100); miscompares++;
        end
    endtask

    task automatic test_irq_handshake();
        logic [31:0] rd;
        logic [31:0] exp;
        bit          pattern [6] = '{0, 1, 0, 1, 0, 1};
        wb_xfer(1'b1, 4'h8, 32'h1, 1'b0, 32'h0, rd);
        wb_xfer(1'b0, 4'h8, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h1) begin
            $display("FAIL ctrl_readback got=%h want=%h", rd, 32'h1); miscompares++;
        end
        vectors++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_idle got=%b want=0", irq); miscompares++;
        end
        push_nonce(32'hC0DE);
        vectors++;
        if (irq !== 1'b1) begin
            $display("FAIL irq_rise got=%b want=1", irq); miscompares++;
        end
        exp = model_q.pop_front();
        wb_xfer(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== exp) begin
            $display("FAIL irq_data got=%h want=%h", rd, exp); miscompares++;
        end
        vectors++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_fall got=%b want=0", irq); miscompares++;
        end
        wb_cycle  = 1'b1;
        wb_strobe = 1'b1;
        wb_we     = 1'b0;
        wb_addr   = 4'hC;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (wb_ack !== pattern[i]) begin
                $display("FAIL ack_pattern%0d got=%b want=%b", i, wb_ack, pattern[i]);
                miscompares++;
            end
            vectors++;
            if (wb_rdata !== (pattern[i] ? ID : 32'h0)) begin
                $display("FAIL id_rdata%0d got=%h want=%h", i, wb_rdata,
                         pattern[i] ? ID : 32'h0);
                miscompares++;
            end
            @(negedge clk);
        end
        wb_cycle  = 1'b0;
        wb_strobe = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_simultaneous();
        test_flush_vs_push();
        test_irq_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
